// File: rtl/sat_sub8_pipe.sv
// Two-stage pipelined signed saturating subtractor, out_diff = sat(in_a - in_b).
// Optional saturation-event counter on sat_cnt when SAT_CNT_EN is defined.
module sat_sub8_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_sat
`ifdef SAT_CNT_EN
    ,
    output logic [CNT_W-1:0] sat_cnt
`endif
);

    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned HH = WIDTH - H;

    logic            r_s1_valid;
    logic [H-1:0]    r_lo;
    logic            r_c_mid;
    logic [HH-1:0]   r_a_hi;
    logic [HH-1:0]   r_nb_hi;
    logic            r_a_msb;
    logic            r_b_msb;
    logic            r_out_valid;
    logic [WIDTH-1:0] r_out_diff;
    logic            r_out_sat;

    logic            w_adv2;
    logic            w_in_xfer;
    logic            w_s2_load;
    logic [H:0]      w_lo_sum;
    logic [HH-1:0]   w_hi;
    logic [WIDTH-1:0] w_raw;
    logic            w_ovf;
    logic [WIDTH-1:0] w_diff;

    // Stage 2 can accept whenever its output slot is empty or draining this cycle.
    assign w_adv2    = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_adv2;
    assign w_in_xfer = in_valid && in_ready;
    assign w_s2_load = r_s1_valid && w_adv2;

    // Low half of a + ~b + 1; the carry out feeds the high half in stage 2.
    assign w_lo_sum = {1'b0, in_a[H-1:0]} + {1'b0, ~in_b[H-1:0]} + {{H{1'b0}}, 1'b1};

    always_comb begin
        w_hi  = r_a_hi + r_nb_hi + {{(HH-1){1'b0}}, r_c_mid};
        w_raw = {w_hi, r_lo};
        w_ovf = (r_a_msb != r_b_msb) && (w_raw[WIDTH-1] != r_a_msb);
        if (!w_ovf) begin
            w_diff = w_raw;
        end else if (r_a_msb) begin
            w_diff = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            w_diff = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_lo       <= '0;
            r_c_mid    <= 1'b0;
            r_a_hi     <= '0;
            r_nb_hi    <= '0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_s1_valid <= 1'b1;
                r_lo       <= w_lo_sum[H-1:0];
                r_c_mid    <= w_lo_sum[H];
                r_a_hi     <= in_a[WIDTH-1:H];
                r_nb_hi    <= ~in_b[WIDTH-1:H];
                r_a_msb    <= in_a[WIDTH-1];
                r_b_msb    <= in_b[WIDTH-1];
            end else if (w_adv2) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_diff  <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            if (w_s2_load) begin
                r_out_diff <= w_diff;
                r_out_sat  <= w_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_diff  = r_out_diff;
    assign out_sat   = r_out_sat;

`ifdef SAT_CNT_EN
    logic [CNT_W-1:0] r_sat_cnt;

    // Sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (r_out_valid && out_ready && r_out_sat && !(&r_sat_cnt)) begin
            r_sat_cnt <= r_sat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign sat_cnt = r_sat_cnt;
`endif

endmodule

// File: tb/tb_sat_sub8_pipe.sv
// Directed self-checking bench for sat_sub8_pipe; counter checks run only when
// SAT_CNT_EN is defined.
module tb_sat_sub8_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_diff;
    logic       out_sat;
`ifdef SAT_CNT_EN
    logic [15:0] sat_cnt;
    logic        rst2_n;
    logic        in_ready2;
    logic        out_valid2;
    logic [7:0]  out_diff2;
    logic        out_sat2;
    logic [1:0]  sat_cnt2;
`endif

    int checks;
    int errors;

    sat_sub8_pipe #(.WIDTH(8), .CNT_W(16)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_diff (out_diff),
        .out_sat  (out_sat)
`ifdef SAT_CNT_EN
        ,
        .sat_cnt  (sat_cnt)
`endif
    );

`ifdef SAT_CNT_EN
    sat_sub8_pipe #(.WIDTH(8), .CNT_W(2)) u_dut2 (
        .clk      (clk),
        .rst_n    (rst2_n),
        .in_valid (in_valid),
        .in_ready (in_ready2),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid2),
        .out_ready(out_ready),
        .out_diff (out_diff2),
        .out_sat  (out_sat2),
        .sat_cnt  (sat_cnt2)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: present one op for one edge (out_ready=1 keeps in_ready high).
    task automatic send_op(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_diff !== 8'h00 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h s=%b want v=0 d=00 s=0",
                     out_valid, out_diff, out_sat);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_diff !== 8'h00) begin
            errors++;
            $display("FAIL reset_idle: got rdy=%b v=%b d=%h want rdy=1 v=0 d=00",
                     in_ready, out_valid, out_diff);
        end
`ifdef SAT_CNT_EN
        checks++;
        if (sat_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_sat_cnt: got %0d want 0", sat_cnt);
        end
`endif
    endtask

    task automatic test_basic();
        logic [7:0] va [4] = '{8'h05, 8'h03, 8'hAA, 8'h80};
        logic [7:0] vb [4] = '{8'h03, 8'h05, 8'hAA, 8'h7F};
        logic [7:0] vd [4] = '{8'h02, 8'hFE, 8'h00, 8'h80};
        logic       vs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_op(va[i], vb[i]);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_latency%0d: out_valid=%b after 1 edge want 0", i, out_valid);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_diff !== vd[i] || out_sat !== vs[i]) begin
                errors++;
                $display("FAIL basic%0d: got v=%b d=%h s=%b want v=1 d=%h s=%b",
                         i, out_valid, out_diff, out_sat, vd[i], vs[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_saturation();
        logic [7:0] va [4] = '{8'h7F, 8'h80, 8'h00, 8'hFF};
        logic [7:0] vb [4] = '{8'h80, 8'h01, 8'h80, 8'h7F};
        logic [7:0] vd [4] = '{8'h7F, 8'h80, 8'h7F, 8'h80};
        logic       vs [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_op(va[i], vb[i]);
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_diff !== vd[i] || out_sat !== vs[i]) begin
                errors++;
                $display("FAIL sat%0d: got v=%b d=%h s=%b want v=1 d=%h s=%b",
                         i, out_valid, out_diff, out_sat, vd[i], vs[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [4] = '{8'h10, 8'hF0, 8'h40, 8'h00};
        logic [7:0] vb [4] = '{8'h20, 8'h10, 8'hC0, 8'h01};
        logic [7:0] vd [4] = '{8'hF0, 8'hE0, 8'h7F, 8'hFF};
        int got = 0;
        int first = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            in_valid = (cyc < 4);
            in_a     = va[cyc % 4];
            in_b     = vb[cyc % 4];
            #1;
            if (in_ready !== 1'b1) begin
                checks++;
                errors++;
                $display("FAIL b2b_ready: cycle %0d in_ready=%b want 1", cyc, in_ready);
            end
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                if (first < 0) first = cyc;
                checks++;
                if (got >= 4 || out_diff !== vd[got % 4]) begin
                    errors++;
                    $display("FAIL b2b_data: result %0d got %h want %h", got, out_diff,
                             vd[got % 4]);
                end
                got++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 4 || first !== 1) begin
            errors++;
            $display("FAIL b2b_count: got %0d results first at %0d want 4 first at 1", got, first);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] va [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
        logic [7:0] vb [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        logic [7:0] vd [4] = '{8'h0F, 8'h1E, 8'h2D, 8'h3C};
        int sent = 0;
        int got = 0;
        logic acc;
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (sent < 4);
            in_a      = va[sent % 4];
            in_b      = vb[sent % 4];
            #1;
            acc = in_valid && in_ready;
            if (cyc == 2 || cyc == 4) begin
                checks++;
                if (in_ready !== 1'b0 || sent !== 2) begin
                    errors++;
                    $display("FAIL bp_ready: cycle %0d in_ready=%b accepted=%0d want 0 and 2",
                             cyc, in_ready, sent);
                end
            end
            if (cyc >= 2 && cyc <= 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_diff !== 8'h0F || out_sat !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_hold: cycle %0d got v=%b d=%h s=%b want v=1 d=0f s=0",
                             cyc, out_valid, out_diff, out_sat);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_diff !== vd[got]) begin
                    errors++;
                    $display("FAIL bp_order: result %0d got %h want %h", got, out_diff, vd[got]);
                end
                got++;
            end
            @(posedge clk);
            if (acc) sent++;
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 4 || sent !== 4) begin
            errors++;
            $display("FAIL bp_drain: got %0d results sent %0d want 4 and 4", got, sent);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_dup: out_valid=%b after drain want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        int stale = 0;
        out_ready = 1'b0;
        send_op(8'h11, 8'h01);
        send_op(8'h22, 8'h02);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ar_setup: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ar_immediate: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) stale++;
        end
        checks++;
        if (stale !== 0) begin
            errors++;
            $display("FAIL ar_stale: %0d cycles with out_valid=1 want 0", stale);
        end
    endtask

`ifdef SAT_CNT_EN
    task automatic test_sat_cnt();
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        #1;
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send_op(8'h7F, 8'h80);
        send_op(8'h05, 8'h03);
        send_op(8'h80, 8'h01);
        send_op(8'h03, 8'h05);
        send_op(8'h00, 8'h80);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sat_cnt !== 16'd3 || sat_cnt2 !== 2'd3) begin
            errors++;
            $display("FAIL sat_cnt_mix: got %0d/%0d want 3/3", sat_cnt, sat_cnt2);
        end
        for (int i = 0; i < 5; i++) send_op(8'h80, 8'h7F);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sat_cnt !== 16'd8 || sat_cnt2 !== 2'd3) begin
            errors++;
            $display("FAIL sat_cnt_clamp: got %0d/%0d want 8/3", sat_cnt, sat_cnt2);
        end
    endtask
`endif

    initial begin
        checks    = 0;
        errors    = 0;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        out_ready = 1'b1;
        rst_n     = 1'b0;
`ifdef SAT_CNT_EN
        rst2_n    = 1'b0;
`endif
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
`ifdef SAT_CNT_EN
        test_sat_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
